// File: rtl/gohome_alarm_pkg.sv
// Shared types and constants for the go-home alarm and related time stages.
package gohome_alarm_pkg;

   localparam int ORA_W   = 5;
   localparam int MINUT_W = 6;

   localparam logic [ORA_W-1:0]   MAX_ORA   = 5'd23;
   localparam logic [MINUT_W-1:0] MAX_MINUT = 6'd59;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_RINGING = 2'd2,
      ST_SNOOZE  = 2'd3
   } state_e;

   // True when hour/minute form a legal time of day.
   function automatic logic time_valid(input logic [ORA_W-1:0]   ora,
                                       input logic [MINUT_W-1:0] minut);
      return (ora <= MAX_ORA) && (minut <= MAX_MINUT);
   endfunction

endpackage

// File: rtl/gohome_alarm_time_add_min.sv
// Adds a minute delta (0..59) to a time of day, wrapping minutes into the
// hour and the hour past 23 back to 0.
module time_add_min
   import gohome_alarm_pkg::*;
(
   input  logic [ORA_W-1:0]   ora_i,
   input  logic [MINUT_W-1:0] minut_i,
   input  logic [MINUT_W-1:0] delta_i,
   output logic [ORA_W-1:0]   ora_o,
   output logic [MINUT_W-1:0] minut_o
);

   localparam logic [MINUT_W:0] MIN_PER_HOUR = 7'd60;

   logic [MINUT_W:0] sum;
   logic [MINUT_W:0] sum_wrap;

   // Single carry is enough because delta never exceeds one hour.
   always_comb begin
      sum      = {1'b0, minut_i} + {1'b0, delta_i};
      sum_wrap = sum - MIN_PER_HOUR;
      minut_o  = sum[MINUT_W-1:0];
      ora_o    = ora_i;
      if (sum >= MIN_PER_HOUR) begin
         minut_o = sum_wrap[MINUT_W-1:0];
         ora_o   = (ora_i >= MAX_ORA) ? '0 : ora_i + 1'b1;
      end
   end

endmodule

// File: rtl/gohome_alarm.sv
// Go-home alarm: watches the running time of day and rings when the stored
// target minute begins; supports snooze, acknowledge and auto-silence.
module gohome_alarm
   import gohome_alarm_pkg::*;
#(
   parameter int SNOOZE_MIN       = 5,
   parameter int RING_TIMEOUT_MIN = 10
) (
   input  logic               clock_i,
   input  logic               reset_i,
   input  logic [ORA_W-1:0]   ora_curenta_i,
   input  logic [MINUT_W-1:0] minut_curent_i,
   input  logic               enable_i,
   input  logic               set_alarm_i,
   input  logic [ORA_W-1:0]   alarm_ore_i,
   input  logic [MINUT_W-1:0] alarm_minute_i,
   input  logic               snooze_i,
   input  logic               ack_i,
   output logic               alarm_on_o,
   output logic               armed_o,
   output logic               snoozed_o,
   output logic               set_err_o,
   output logic [ORA_W-1:0]   target_ore_o,
   output logic [MINUT_W-1:0] target_minute_o
);

   localparam logic [MINUT_W-1:0] SNOOZE_DELTA = MINUT_W'(SNOOZE_MIN);
   localparam logic [MINUT_W:0]   RING_LAST    = (MINUT_W+1)'(RING_TIMEOUT_MIN - 1);

   state_e               state_q, state_d;
   logic [ORA_W-1:0]     tgt_ore_q, tgt_ore_d;
   logic [MINUT_W-1:0]   tgt_min_q, tgt_min_d;
   logic [ORA_W-1:0]     snz_ore_q, snz_ore_d;
   logic [MINUT_W-1:0]   snz_min_q, snz_min_d;
   logic [MINUT_W-1:0]   ring_cnt_q, ring_cnt_d;
   logic [MINUT_W-1:0]   prev_min_q;
   logic                 set_err_d;
   logic                 alarm_on_q, armed_q, snoozed_q, set_err_q;

   logic                 tick, match_t, match_s;
   logic                 set_ok, set_bad;
   logic [MINUT_W:0]     cnt_inc;
   logic [ORA_W-1:0]     snz_ore_nx;
   logic [MINUT_W-1:0]   snz_min_nx;

   time_add_min u_snooze_add (
      .ora_i   (ora_curenta_i),
      .minut_i (minut_curent_i),
      .delta_i (SNOOZE_DELTA),
      .ora_o   (snz_ore_nx),
      .minut_o (snz_min_nx)
   );

   // Previous minute tracks the counter unconditionally so the first cycle
   // after reset does not see a spurious tick.
   always_ff @(posedge clock_i) begin
      prev_min_q <= minut_curent_i;
   end

   assign tick    = (minut_curent_i != prev_min_q);
   assign match_t = tick && (ora_curenta_i == tgt_ore_q) && (minut_curent_i == tgt_min_q);
   assign match_s = tick && (ora_curenta_i == snz_ore_q) && (minut_curent_i == snz_min_q);
   assign set_bad = set_alarm_i && !time_valid(alarm_ore_i, alarm_minute_i);
   assign set_ok  = set_alarm_i && !set_bad;
   assign cnt_inc = {1'b0, ring_cnt_q} + 1'b1;

   // Next-state logic in priority order: enable, set, ack, snooze, normal.
   always_comb begin
      state_d    = state_q;
      tgt_ore_d  = tgt_ore_q;
      tgt_min_d  = tgt_min_q;
      snz_ore_d  = snz_ore_q;
      snz_min_d  = snz_min_q;
      ring_cnt_d = ring_cnt_q;
      set_err_d  = set_bad;

      if (set_ok) begin
         tgt_ore_d = alarm_ore_i;
         tgt_min_d = alarm_minute_i;
      end

      if (!enable_i) begin
         state_d = ST_IDLE;
      end else if (set_ok) begin
         state_d = ST_ARMED;
      end else if (set_bad) begin
         // rejected load: hold state, nothing else happens this cycle
         state_d = state_q;
      end else if (ack_i && (state_q == ST_RINGING || state_q == ST_SNOOZE)) begin
         state_d    = ST_ARMED;
         ring_cnt_d = '0;
      end else if (snooze_i && state_q == ST_RINGING) begin
         state_d   = ST_SNOOZE;
         snz_ore_d = snz_ore_nx;
         snz_min_d = snz_min_nx;
      end else begin
         case (state_q)
            ST_ARMED: begin
               if (match_t) begin
                  state_d    = ST_RINGING;
                  ring_cnt_d = '0;
               end
            end
            ST_SNOOZE: begin
               if (match_s) begin
                  state_d    = ST_RINGING;
                  ring_cnt_d = '0;
               end
            end
            ST_RINGING: begin
               if (tick) begin
                  ring_cnt_d = cnt_inc[MINUT_W-1:0];
                  if (cnt_inc >= RING_LAST) state_d = ST_ARMED;
               end
            end
            default: state_d = state_q;
         endcase
      end
   end

   // State, targets, counter and registered outputs.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q    <= ST_IDLE;
         tgt_ore_q  <= '0;
         tgt_min_q  <= '0;
         snz_ore_q  <= '0;
         snz_min_q  <= '0;
         ring_cnt_q <= '0;
         alarm_on_q <= 1'b0;
         armed_q    <= 1'b0;
         snoozed_q  <= 1'b0;
         set_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         tgt_ore_q  <= tgt_ore_d;
         tgt_min_q  <= tgt_min_d;
         snz_ore_q  <= snz_ore_d;
         snz_min_q  <= snz_min_d;
         ring_cnt_q <= ring_cnt_d;
         alarm_on_q <= (state_d == ST_RINGING);
         armed_q    <= (state_d != ST_IDLE);
         snoozed_q  <= (state_d == ST_SNOOZE);
         set_err_q  <= set_err_d;
      end
   end

   assign alarm_on_o      = alarm_on_q;
   assign armed_o         = armed_q;
   assign snoozed_o       = snoozed_q;
   assign set_err_o       = set_err_q;
   assign target_ore_o    = tgt_ore_q;
   assign target_minute_o = tgt_min_q;

endmodule

// File: tb/tb_gohome_alarm.sv
// Bench for gohome_alarm: minute-of-day reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_gohome_alarm;

   localparam int SN = 5;
   localparam int RT = 10;

   logic       clk = 1'b0;
   logic       rst = 1'b1, en = 1'b0, set = 1'b0, snz = 1'b0, ack = 1'b0;
   logic [4:0] h = '0, ah = '0;
   logic [5:0] m = '0, am = '0;
   logic       alarm_on, armed, snoozed, set_err;
   logic [4:0] t_ore;
   logic [5:0] t_min;

   int total = 0;
   int bad   = 0;
   bit go    = 1'b0;

   // reference model state
   bit mring = 0, msnz = 0, marm = 0, merr = 0;
   int mth = 0, mtm = 0, msn = 0, mcnt = 0, mpm = 0;

   gohome_alarm #(.SNOOZE_MIN(SN), .RING_TIMEOUT_MIN(RT)) dut (
      .clock_i         (clk),
      .reset_i         (rst),
      .ora_curenta_i   (h),
      .minut_curent_i  (m),
      .enable_i        (en),
      .set_alarm_i     (set),
      .alarm_ore_i     (ah),
      .alarm_minute_i  (am),
      .snooze_i        (snz),
      .ack_i           (ack),
      .alarm_on_o      (alarm_on),
      .armed_o         (armed),
      .snoozed_o       (snoozed),
      .set_err_o       (set_err),
      .target_ore_o    (t_ore),
      .target_minute_o (t_min)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Model: times as minute-of-day, states as plain flags.
   always @(posedge clk) begin : model
      int  now;
      bit  tick, err, ok;
      now  = int'(h) * 60 + int'(m);
      tick = (int'(m) != mpm);
      err  = set && (ah > 23 || am > 59);
      ok   = set && !err;
      if (rst) begin
         mring = 0; msnz = 0; marm = 0; merr = 0;
         mth = 0; mtm = 0; msn = 0; mcnt = 0;
      end else begin
         merr = err;
         if (ok) begin mth = int'(ah); mtm = int'(am); end
         if (!en) begin
            mring = 0; msnz = 0; marm = 0;
         end else if (ok) begin
            marm = 1; mring = 0; msnz = 0;
         end else if (err) begin
            mcnt = mcnt;
         end else if (ack && (mring || msnz)) begin
            mring = 0; msnz = 0; marm = 1; mcnt = 0;
         end else if (snz && mring) begin
            mring = 0; msnz = 1; msn = (now + SN) % 1440;
         end else if (marm && !mring && !msnz) begin
            if (tick && now == mth * 60 + mtm) begin mring = 1; mcnt = 0; end
         end else if (msnz) begin
            if (tick && now == msn) begin msnz = 0; mring = 1; mcnt = 0; end
         end else if (mring && tick) begin
            mcnt++;
            if (mcnt >= RT - 1) mring = 0;
         end
      end
      mpm = int'(m);
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (go) begin
         chk("m_alarm_on", int'(alarm_on), int'(mring));
         chk("m_armed",    int'(armed),    int'(marm));
         chk("m_snoozed",  int'(snoozed),  int'(msnz));
         chk("m_set_err",  int'(set_err),  int'(merr));
         chk("m_tgt_ore",  int'(t_ore),    mth);
         chk("m_tgt_min",  int'(t_min),    mtm);
      end
   end

   initial begin
      repeat (3) cyc();
      go = 1'b1;
      chk("rst_alarm", int'(alarm_on), 0);
      chk("rst_armed", int'(armed), 0);
      chk("rst_tgt",   int'(t_ore) * 60 + int'(t_min), 0);

      // 1: basic ring and timeout
      rst = 0; en = 1; set = 1; ah = 17; am = 30; h = 17; m = 29;
      cyc();
      set = 0;
      chk("t1_armed", int'(armed), 1);
      chk("t1_tgt", int'(t_ore) * 60 + int'(t_min), 17 * 60 + 30);
      repeat (9) cyc();
      chk("t1_pre", int'(alarm_on), 0);
      m = 30;
      cyc();
      chk("t1_rise", int'(alarm_on), 1);
      for (int k = 31; k <= 39; k++) begin
         m = 6'(k);
         repeat (3) cyc();
         if (k == 38) chk("t1_still", int'(alarm_on), 1);
      end
      chk("t1_tmo", int'(alarm_on), 0);
      chk("t1_rearm", int'(armed), 1);

      // 2: snooze across midnight
      set = 1; ah = 23; am = 58;
      cyc();
      set = 0; h = 23; m = 57;
      repeat (3) cyc();
      m = 58;
      cyc();
      chk("t2_ring", int'(alarm_on), 1);
      snz = 1;
      cyc();
      snz = 0;
      chk("t2_snz", int'(snoozed), 1);
      chk("t2_quiet", int'(alarm_on), 0);
      h = 0; m = 2;
      repeat (5) cyc();
      chk("t2_0002", int'(alarm_on), 0);
      m = 3;
      cyc();
      chk("t2_0003", int'(alarm_on), 1);
      ack = 1;
      cyc();
      ack = 0;
      chk("t2_ack", int'(alarm_on), 0);

      // 3: ack beats snooze; 6: no retrigger in the same minute
      set = 1; ah = 17; am = 30;
      cyc();
      set = 0; h = 17; m = 29;
      repeat (2) cyc();
      m = 30;
      cyc();
      chk("t3_ring", int'(alarm_on), 1);
      ack = 1; snz = 1;
      cyc();
      ack = 0; snz = 0;
      chk("t3_alarm", int'(alarm_on), 0);
      chk("t3_snz", int'(snoozed), 0);
      chk("t3_armed", int'(armed), 1);
      repeat (64) cyc();
      chk("t6_hold", int'(alarm_on), 0);
      m = 29;
      cyc();
      m = 30;
      cyc();
      chk("t6_reload", int'(alarm_on), 1);

      // 4: illegal loads
      set = 1; ah = 24; am = 10;
      cyc();
      set = 0;
      chk("t4_err1", int'(set_err), 1);
      chk("t4_ore", int'(t_ore), 17);
      cyc();
      chk("t4_pulse1", int'(set_err), 0);
      set = 1; ah = 12; am = 60;
      cyc();
      set = 0;
      chk("t4_err2", int'(set_err), 1);
      chk("t4_min", int'(t_min), 30);
      cyc();
      chk("t4_pulse2", int'(set_err), 0);
      chk("t4_ringing", int'(alarm_on), 1);

      // 5: enable drop, then reset while ringing
      en = 0;
      cyc();
      chk("t5_off", int'(alarm_on), 0);
      chk("t5_disarm", int'(armed), 0);
      en = 1;
      repeat (3) cyc();
      chk("t5_idle", int'(armed), 0);
      set = 1; ah = 17; am = 30;
      cyc();
      set = 0; m = 29;
      cyc();
      m = 30;
      cyc();
      chk("t5_ring", int'(alarm_on), 1);
      rst = 1;
      cyc();
      rst = 0;
      chk("t5_rst_alarm", int'(alarm_on), 0);
      chk("t5_rst_armed", int'(armed), 0);
      chk("t5_rst_tgt", int'(t_ore) * 60 + int'(t_min), 0);
      repeat (2) cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
